// File: rtl/float_norm_pkg.sv
// Shared types and helpers for the iterative leading-one normaliser.
package float_norm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_e;

    // Minimum exponent width able to index every bit of a WIDTH-bit operand
    function automatic int exp_w_of(input int width);
        exp_w_of = (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/float_norm_iter.sv
// Iterative normaliser: shifts an unsigned operand left one bit per cycle
// until its leading one reaches the MSB, reporting the original bit index.
module float_norm_iter
    import float_norm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int EXP_W = exp_w_of(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] u,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic [EXP_W-1:0] p,
    output logic             z
);

    if (WIDTH < 2) begin : g_bad_width
        $fatal(1, "float_norm_iter: WIDTH must be at least 2");
    end
    if (EXP_W < exp_w_of(WIDTH)) begin : g_bad_exp_w
        $fatal(1, "float_norm_iter: EXP_W too narrow for WIDTH");
    end

    norm_state_e      state_r;
    norm_state_e      state_next_s;
    logic [WIDTH-1:0] work_r;
    logic [EXP_W-1:0] cnt_r;
    logic             msb_s;

    assign msb_s = work_r[WIDTH-1];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = (u == '0) ? DONE : SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (msb_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Handshake outputs decoded purely from the state register
    always_comb begin
        in_ready  = (state_r == IDLE);
        out_valid = (state_r == DONE);
    end

    // Working register, exponent counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_r <= '0;
            cnt_r  <= '0;
            f      <= '0;
            p      <= '0;
            z      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        work_r <= u;
                        cnt_r  <= EXP_W'(WIDTH - 1);
                        if (u == '0) begin
                            f <= '0;
                            p <= '0;
                            z <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    // A non-zero operand reaches the MSB before cnt_r can wrap
                    if (msb_s) begin
                        f <= work_r;
                        p <= cnt_r;
                        z <= 1'b0;
                    end else begin
                        work_r <= {work_r[WIDTH-2:0], 1'b0};
                        cnt_r  <= cnt_r - EXP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float_norm_iter.sv
// Self-checking bench for float_norm_iter at WIDTH=8 and WIDTH=16.
module tb_float_norm_iter;

    logic        clk;
    logic        rst_n;
    logic        iv;
    logic        ordy;
    logic [15:0] uu;
    logic        sel16;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, z8;
    logic [7:0]  f8;
    logic [2:0]  p8;
    logic        in_valid16, in_ready16, out_valid16, out_ready16, z16;
    logic [15:0] f16;
    logic [3:0]  p16;

    logic        in_ready_s, out_valid_s, z_s;
    logic [15:0] f_s;
    logic [3:0]  p_s;

    int n_assert = 0;
    int n_fail   = 0;
    logic [15:0] last_f [2];
    int          last_p [2];
    logic        last_z [2];

    assign in_valid8   = iv & ~sel16;
    assign in_valid16  = iv & sel16;
    assign out_ready8  = ordy & ~sel16;
    assign out_ready16 = ordy & sel16;
    assign in_ready_s  = sel16 ? in_ready16 : in_ready8;
    assign out_valid_s = sel16 ? out_valid16 : out_valid8;
    assign f_s         = sel16 ? f16 : {8'h00, f8};
    assign p_s         = sel16 ? p16 : {1'b0, p8};
    assign z_s         = sel16 ? z16 : z8;

    float_norm_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .u(uu[7:0]), .out_valid(out_valid8), .out_ready(out_ready8),
        .f(f8), .p(p8), .z(z8)
    );

    float_norm_iter #(.WIDTH(16), .EXP_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .u(uu), .out_valid(out_valid16), .out_ready(out_ready16),
        .f(f16), .p(p16), .z(z16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: highest set bit, shift distance and cycle count from first principles
    task automatic ref_norm(input int w, input logic [15:0] v, output logic [15:0] ef,
                            output int ep, output logic ez, output int elat);
        ez   = (v == 16'h0000);
        ep   = 0;
        ef   = 16'h0000;
        elat = 1;
        if (!ez) begin
            for (int i = 0; i < w; i++) if (v[i]) ep = i;
            ef   = v << (w - 1 - ep);
            elat = (w - 1 - ep) + 2;
        end
    endtask

    task automatic run(input int w, input logic [15:0] v, input int hold);
        logic [15:0] ef;
        int          ep, elat, cyc, idx;
        logic        ez;
        idx = (w == 16) ? 1 : 0;
        ref_norm(w, v, ef, ep, ez, elat);
        sel16 = (w == 16);
        #1;
        check("in_ready_idle", in_ready_s, 1);
        iv = 1'b1;
        uu = v;
        @(posedge clk);
        @(negedge clk);
        cyc = 1;
        while (!out_valid_s && cyc < 40) begin
            check("busy_in_ready", in_ready_s, 0);
            check("retain_f", f_s, last_f[idx]);
            check("retain_p", p_s, last_p[idx]);
            check("retain_z", z_s, last_z[idx]);
            iv   = 1'($urandom_range(0, 1));
            uu   = 16'($urandom);
            ordy = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
        end
        iv   = 1'b0;
        ordy = 1'b0;
        check("latency", cyc, elat);
        check("f", f_s, ef);
        check("p", p_s, ep);
        check("z", z_s, ez);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid_s, 1);
            check("bp_in_ready", in_ready_s, 0);
            check("bp_f", f_s, ef);
            check("bp_p", p_s, ep);
            check("bp_z", z_s, ez);
        end
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        check("release_in_ready", in_ready_s, 1);
        check("release_out_valid", out_valid_s, 0);
        last_f[idx] = ef;
        last_p[idx] = ep;
        last_z[idx] = ez;
    endtask

    initial begin
        rst_n = 1'b0;
        iv    = 1'b0;
        ordy  = 1'b0;
        uu    = 16'h0000;
        sel16 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            last_f[i] = 16'h0000;
            last_p[i] = 0;
            last_z[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("rst_out_valid8", out_valid8, 0);
        check("rst_in_ready8", in_ready8, 1);
        check("rst_f8", f8, 0);
        check("rst_z16", z16, 0);
        check("rst_in_ready16", in_ready16, 1);
        rst_n = 1'b1;
        @(negedge clk);

        run(8, 16'h0005, 3);
        run(8, 16'h0080, 0);
        run(8, 16'h0001, 1);
        run(8, 16'h0000, 2);
        run(8, 16'h0040, 0);

        // Reset in the middle of a long shift sequence
        sel16 = 1'b0;
        iv    = 1'b1;
        uu    = 16'h0001;
        @(posedge clk);
        @(negedge clk);
        iv = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid_s, 0);
        check("mid_rst_in_ready", in_ready_s, 1);
        check("mid_rst_f", f_s, 0);
        check("mid_rst_p", p_s, 0);
        check("mid_rst_z", z_s, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            last_f[i] = 16'h0000;
            last_p[i] = 0;
            last_z[i] = 1'b0;
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("post_rst_no_result", out_valid_s, 0);
            check("post_rst_in_ready", in_ready_s, 1);
        end

        run(16, 16'h0300, 1);
        run(16, 16'h0001, 0);
        run(16, 16'h8000, 2);
        run(16, 16'h0000, 0);
        for (int i = 0; i < 8; i++) run(16, 16'($urandom), $urandom_range(0, 2));

        for (int v = 0; v < 256; v++) run(8, 16'(v), $urandom_range(0, 3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/float_norm_iter.md
FLOAT_NORM_ITER -- requirements
Module: float_norm_iter

Interface
REQ-001 Parameter WIDTH, default 8: integer width of input U and mantissa output F; WIDTH >= 2 SHALL be enforced by elaboration-time check.
REQ-002 Parameter EXP_W, default $clog2(WIDTH): width of exponent output P; overriding it to a value below $clog2(WIDTH) SHALL fail elaboration.
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 IN_VALID  input  1  U holds a valid operand.
REQ-006 IN_READY  output  1  block can accept an operand.
REQ-007 U  input  WIDTH  unsigned operand.
REQ-008 OUT_VALID  output  1  F/P/Z hold a valid result.
REQ-009 OUT_READY  input  1  consumer accepts the result.
REQ-010 F  output  WIDTH  normalised mantissa, leading one at bit WIDTH-1.
REQ-011 P  output  EXP_W  bit index of the leading one of U.
REQ-012 Z  output  1  operand was zero.

Function
REQ-013 Result SHALL be P = index of the most significant 1 in U, F = U << (WIDTH-1-P), Z = 0; for U = 0: F = 0, P = 0, Z = 1.
REQ-014 FSM states SHALL be IDLE, SHIFT, DONE; IN_READY = (state == IDLE), OUT_VALID = (state == DONE), both decoded from state only.
REQ-015 IDLE: on IN_VALID && IN_READY, capture U into a WIDTH-bit working register and set the exponent counter to WIDTH-1; go to DONE if U = 0 (result F=0, P=0, Z=1 registered), else go to SHIFT.
REQ-016 SHIFT: if working[WIDTH-1] = 1, register F = working, P = counter, Z = 0 and go to DONE; else shift working left by 1 (zero fill) and decrement counter, stay in SHIFT.
REQ-017 Latency: with acceptance in cycle c and k = leading zeros of U, OUT_VALID SHALL first be high in cycle c+k+2 for U != 0 and in cycle c+1 for U = 0.
REQ-018 DONE: F, P, Z SHALL hold stable while OUT_VALID && !OUT_READY; on OUT_READY, go to IDLE (new operand accepted no earlier than the following cycle).
REQ-019 F, P, Z SHALL change only on entry to DONE; they retain the previous result during IDLE and SHIFT.
REQ-020 U and IN_VALID SHALL be ignored outside IDLE; OUT_READY SHALL be ignored outside DONE.
REQ-021 The counter SHALL never underflow: for U != 0 at most WIDTH-1 shifts occur.

Reset
REQ-022 RST_N low SHALL immediately force state IDLE, working register 0, counter 0, F 0, P 0, Z 0; hence OUT_VALID = 0 and IN_READY = 1 while in reset.
REQ-023 Reset asserted in SHIFT or DONE SHALL discard the operation in flight without producing a result.

Structure
REQ-024 Shared package float_norm_pkg SHALL hold the state enum type (IDLE/SHIFT/DONE) and a clog2-based exponent-width helper.
REQ-025 Single module, no sub-module; WIDTH-generic, no per-width tables.

Verification
REQ-026 WIDTH=8, U=0x05 accepted cycle c -> OUT_VALID first high in cycle c+7, F=0xA0, P=2, Z=0.
REQ-027 WIDTH=8: U=0x80 -> F=0x80, P=7, OUT_VALID in c+2; U=0x01 -> F=0x80, P=0, OUT_VALID in c+9; U=0x00 -> F=0x00, P=0, Z=1, OUT_VALID in c+1.
REQ-028 Backpressure: hold OUT_READY low 3 cycles after OUT_VALID -> F/P/Z stable and IN_READY = 0 throughout; OUT_READY high -> IN_READY = 1 in the next cycle.
REQ-029 Reset: drive RST_N low mid-SHIFT after accepting U=0x01 -> OUT_VALID = 0, IN_READY = 1, F=P=Z=0 immediately; no result follows after release.
REQ-030 WIDTH=16, EXP_W=4: U=0x0300 -> F=0xC000, P=9, OUT_VALID in c+8; exhaustive sweep of all 8-bit U values against REQ-013 with random OUT_READY.
